// File: rtl/dizy_stream_ctrl_pkg.sv
// Shared constants and types for the DIZY keystream controller and its output FIFO.
// Cipher widths default to the SIZE_STATE/SIZE_KEY macros when the build defines them.
`ifndef SIZE_STATE
`define SIZE_STATE 64
`endif
`ifndef SIZE_KEY
`define SIZE_KEY 128
`endif

package dizy_stream_ctrl_pkg;

  localparam int unsigned DIZY_SIZE_STATE = `SIZE_STATE;
  localparam int unsigned DIZY_SIZE_KEY   = `SIZE_KEY;

  // Depth must stay a power of two: FIFO pointers wrap by overflow.
  localparam int KS_FIFO_DEPTH = 2;
  localparam int KS_OCC_W      = $clog2(KS_FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } ctrl_state_e;

  // FIFO occupancy after a push, given the current occupancy and a same-cycle pop.
  function automatic logic [KS_OCC_W-1:0] ks_occ_after(input logic [KS_OCC_W-1:0] occ,
                                                       input logic                pop);
    return occ + KS_OCC_W'(1) - KS_OCC_W'(pop);
  endfunction

endpackage

// File: rtl/dizy_ks_fifo.sv
// Two-entry first-word-fall-through buffer for keystream blocks.
// The head entry is always visible on rdata_o; flush empties it in one cycle.
module dizy_ks_fifo
  import dizy_stream_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 65
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push_i,
  input  logic [WIDTH-1:0]    wdata_i,
  input  logic                pop_i,
  input  logic                flush_i,
  output logic                valid_o,
  output logic [WIDTH-1:0]    rdata_o,
  output logic [KS_OCC_W-1:0] occ_o
);

  localparam int PTR_W = (KS_FIFO_DEPTH > 1) ? $clog2(KS_FIFO_DEPTH) : 1;

  logic [WIDTH-1:0]    mem_q [KS_FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [KS_OCC_W-1:0] occ_q;
  logic                do_pop;

  assign do_pop  = pop_i && (occ_q != '0);
  assign valid_o = (occ_q != '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign occ_o   = occ_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is reset on purpose so the head word reads zero during reset.
      for (int i = 0; i < KS_FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      occ_q <= occ_q + KS_OCC_W'(push_i) - KS_OCC_W'(do_pop);
    end
  end

endmodule

// File: rtl/dizy_stream_ctrl.sv
// Sequences an external DIZY round core to produce a keystream of nblocks blocks
// (0 = endless), buffering results in a 2-entry FIFO with backpressure.
module dizy_stream_ctrl
  import dizy_stream_ctrl_pkg::*;
#(
  parameter int unsigned SIZE_STATE = DIZY_SIZE_STATE,
  parameter int unsigned SIZE_KEY   = DIZY_SIZE_KEY,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_valid,
  output logic                  init_ready,
  input  logic [SIZE_KEY-1:0]   init_key,
  input  logic [CNT_W-1:0]      init_nblocks,
  input  logic                  abort,
  output logic                  core_load,
  output logic                  core_next,
  output logic [SIZE_KEY-1:0]   core_key,
  input  logic                  core_busy,
  input  logic [SIZE_STATE-1:0] core_state,
  output logic                  ks_valid,
  input  logic                  ks_ready,
  output logic [SIZE_STATE-1:0] ks_data,
  output logic                  ks_last,
  output logic                  done
);

  ctrl_state_e         state_q, state_d;
  logic [SIZE_KEY-1:0] key_q;
  logic [CNT_W-1:0]    nblk_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    blk_inc;
  logic                cmd_q;
  logic                rdy_en_q;
  logic                accept;
  logic                push;
  logic                flush;
  logic                pop;
  logic                last;
  logic [KS_OCC_W-1:0] occ;
  logic [SIZE_STATE:0] head;

  assign blk_inc  = cnt_q + CNT_W'(1);
  assign last     = (nblk_q != '0) && (blk_inc == nblk_q);
  assign pop      = ks_valid && ks_ready;
  assign core_key = key_q;
  assign ks_last  = head[SIZE_STATE];
  assign ks_data  = head[SIZE_STATE-1:0];

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    core_load  = 1'b0;
    core_next  = 1'b0;
    push       = 1'b0;
    flush      = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    init_ready = rdy_en_q && (state_q == ST_IDLE) && !core_busy && !abort;
    if (abort) begin
      state_d = ST_IDLE;
      flush   = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: if (init_valid && init_ready) begin
          accept  = 1'b1;
          state_d = ST_LOAD;
        end
        ST_LOAD: begin
          core_load = 1'b1;
          state_d   = ST_WAIT;
        end
        // cmd_q masks the cycle right after a command, before core_busy can rise.
        ST_WAIT: if (!core_busy && !cmd_q) begin
          push = 1'b1;
          if (last) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end else if (ks_occ_after(occ, pop) <= KS_OCC_W'(1)) begin
            core_next = 1'b1;
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: if (occ < KS_OCC_W'(KS_FIFO_DEPTH)) begin
          core_next = 1'b1;
          state_d   = ST_WAIT;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cmd_q    <= 1'b0;
      rdy_en_q <= 1'b0;
      key_q    <= '0;
      nblk_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= core_load || core_next;
      rdy_en_q <= 1'b1;
      if (accept) begin
        key_q  <= init_key;
        nblk_q <= init_nblocks;
        cnt_q  <= '0;
      end else if (push) begin
        cnt_q <= blk_inc;
      end
    end
  end

  dizy_ks_fifo #(
    .WIDTH(SIZE_STATE + 1)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .wdata_i({last, core_state}),
    .pop_i  (pop),
    .flush_i(flush),
    .valid_o(ks_valid),
    .rdata_o(head),
    .occ_o  (occ)
  );

endmodule

// File: doc/dizy_stream_ctrl.md
DIZY_STREAM_CTRL -- requirements
Module: dizy_stream_ctrl

Interface
REQ-001 SHALL have parameter SIZE_STATE, default `SIZE_STATE, meaning cipher state / keystream block width.
REQ-002 SHALL have parameter SIZE_KEY, default `SIZE_KEY, meaning key/IV width.
REQ-003 SHALL have parameter CNT_W, default 16, meaning block-counter width.
REQ-004 SHALL provide one clock and an asynchronous active-low reset, named clk and rst_n (decided).
REQ-005 Port: clk  in  1  rising-edge clock.
REQ-006 Port: rst_n  in  1  asynchronous active-low reset.
REQ-007 Port: init_valid  in  1  stream request offered.
REQ-008 Port: init_ready  out  1  request accepted when init_valid & init_ready.
REQ-009 Port: init_key  in  SIZE_KEY  key/IV for the stream.
REQ-010 Port: init_nblocks  in  CNT_W  blocks to produce; 0 = unlimited.
REQ-011 Port: abort  in  1  synchronous stream cancel.
REQ-012 Port: core_load, core_next  out  1 each  single-cycle commands to the round core.
REQ-013 Port: core_key  out  SIZE_KEY  registered key held stable for the whole stream.
REQ-014 Port: core_busy  in  1; core_state  in  SIZE_STATE  round-core status and result.
REQ-015 Port: ks_valid  out  1; ks_ready  in  1; ks_data  out  SIZE_STATE; ks_last  out  1  keystream output handshake.
REQ-016 Port: done  out  1  one-cycle pulse when the final block of a finite stream is captured.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, WAIT, HOLD.
REQ-018 IDLE: init_ready = !core_busy; on handshake, latch init_key into core_key and init_nblocks; clear block counter; go to LOAD.
REQ-019 LOAD: assert core_load for exactly one cycle; go to WAIT.
REQ-020 WAIT: while core_busy = 1, hold. On the first cycle with core_busy = 0, push {core_state, last} into the output FIFO and increment the block counter modulo 2^CNT_W.
REQ-021 last SHALL be 1 when nblocks != 0 and the incremented counter equals nblocks. On a last push: pulse done and go to IDLE.
REQ-022 On a non-last push, if FIFO occupancy after the push is at most 1: assert core_next in the same cycle and stay in WAIT. Otherwise go to HOLD.
REQ-023 HOLD: assert core_next in the first cycle in which FIFO occupancy (registered) is below 2, then go to WAIT.
REQ-024 core_load and core_next SHALL never be asserted together or in consecutive cycles. A push SHALL never target a full FIFO.
REQ-025 Output FIFO: 2 entries, first-word fall-through. ks_valid = not empty; ks_data/ks_last are taken from the head entry; pop on ks_valid & ks_ready. Simultaneous push and pop leaves occupancy unchanged.
REQ-026 ks_data SHALL stay stable while ks_valid & !ks_ready.
REQ-027 abort (any state) SHALL: go to IDLE next cycle, flush the FIFO, suppress core_load/core_next and the push in that cycle, and not pulse done. A new request is accepted only once core_busy = 0.
REQ-028 abort has priority over init_valid when both are asserted in the same cycle.
REQ-029 Latency with a 15-round/5-per-cycle core: ks_valid rises 5 cycles after the init handshake cycle. With ks_ready held at 1, the steady-state rate is 1 block per 3 cycles.
REQ-030 nblocks = 0 SHALL stream indefinitely; the counter wraps and ks_last is never set.

Reset
REQ-031 While rst_n = 0: state IDLE, FIFO empty, counter 0, core_key 0. Outputs: ks_valid = 0, ks_last = 0, ks_data = 0, done = 0, core_load = 0, core_next = 0, init_ready = 0.
REQ-032 init_ready SHALL follow REQ-018 from the first clock edge after rst_n deasserts. Reset mid-stream discards all buffered blocks.

Structure
REQ-033 State encoding and FIFO depth constant SHALL live in a shared package/header alongside params_dizy.vh.
REQ-034 The 2-entry FIFO SHALL be a sub-module named dizy_ks_fifo. The round core is instantiated outside this block.

Verification
REQ-035 nblocks = 3, ks_ready = 1 -> ks_valid first asserted at cycle +5; then 3 blocks 3 cycles apart; ks_last and done on the 3rd block; core_load pulsed once and core_next twice.
REQ-036 nblocks = 4, ks_ready = 0 -> 2 blocks buffered, FSM in HOLD with no core_next. Raising ks_ready drains the FIFO in order; the remaining 2 blocks follow; data matches the golden keystream.
REQ-037 abort asserted in WAIT -> FIFO empty and ks_valid = 0 next cycle, no done. A new init_valid is refused until core_busy = 0, then accepted.
REQ-038 nblocks = 0 with ks_ready = 1 for 70000 blocks -> no ks_last and no done; counter wraps at 2^16 without stalling.
REQ-039 rst_n pulsed low mid-stream with 1 block buffered -> all outputs take the REQ-031 values immediately, without waiting for a clock edge.
REQ-040 Random ks_ready backpressure with an assertion monitor -> REQ-024 and REQ-026 never violated.
